// File: rtl/coffee_recipe_sequencer_if.sv
// Coffee recipe sequencer bus.
// Carries the order request from the price comparator (price-OK, type, cancel),
// the dispense-timer handshake (start_timer/t_expired) and the valve/status
// outputs (ing_type, busy, done, error, led).
//   master : the side that places orders and runs the timer (upstream + timer)
//   slave  : the sequencer itself
interface coffee_recipe_sequencer_if #(
    parameter int NUM_TYPES = 4,
    parameter int TYPE_W    = 2,
    parameter int ING_W     = 3
);
    logic                  comparador_de_precio_ok;
    logic [TYPE_W-1:0]     c_type;
    logic                  cancel;
    logic                  t_expired;
    logic [ING_W-1:0]      ing_type;
    logic                  start_timer;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [NUM_TYPES-1:0]  led;

    modport master (
        output comparador_de_precio_ok, c_type, cancel, t_expired,
        input  ing_type, start_timer, busy, done, error, led
    );

    modport slave (
        input  comparador_de_precio_ok, c_type, cancel, t_expired,
        output ing_type, start_timer, busy, done, error, led
    );
endinterface

// File: rtl/coffee_recipe_sequencer.sv
// Coffee recipe sequencer.
// After a price-OK it latches the coffee type and walks that type's ingredient
// mask from the lowest set bit upward, opening one valve at a time and
// handshaking each step with the external dispense timer. Supports cancel,
// a per-step watchdog, invalid-type detection and a one-cycle done pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of coffee_recipe_sequencer_if
//           in : comparador_de_precio_ok, c_type, cancel, t_expired
//           out: ing_type (index+1, 0 = none), start_timer, busy, done, error, led
// All outputs are registered.
module coffee_recipe_sequencer #(
    parameter int                          NUM_TYPES = 4,
    parameter int                          TYPE_W    = 2,
    parameter int                          NUM_ING   = 5,
    parameter int                          ING_W     = 3,
    parameter logic [NUM_TYPES*NUM_ING-1:0] RECIPE   = 20'h9B4E3,
    parameter int                          WDOG_W    = 16,
    parameter int                          WDOG_MAX  = 50000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    coffee_recipe_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [TYPE_W-1:0]      type_q, type_d;
    logic [ING_W-1:0]       idx_q, idx_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic [ING_W-1:0]       ing_q, ing_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [NUM_TYPES-1:0]   led_q, led_d;
    logic [ING_W:0]         hit;   // {found, index}
    logic [WDOG_W-1:0]      wdog_inc;

    // Ingredient mask of a type; out-of-range types read as an empty mask.
    function automatic logic [NUM_ING-1:0] mask_of(input logic [TYPE_W-1:0] t);
        mask_of = '0;
        if (int'(t) < NUM_TYPES) mask_of = RECIPE[int'(t)*NUM_ING +: NUM_ING];
    endfunction

    // Lowest set bit of m at or above position 'from'.
    function automatic logic [ING_W:0] first_set(input logic [NUM_ING-1:0] m,
                                                 input int from);
        first_set = '0;
        for (int i = NUM_ING - 1; i >= 0; i--) begin
            if (m[i] && i >= from) first_set = {1'b1, ING_W'(i)};
        end
    endfunction

    assign wdog_inc = wdog_q + WDOG_W'(1);

    // NOTE: every variable assigned here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        ing_d   = ing_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        hit     = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.comparador_de_precio_ok && !bus.cancel) begin
                    type_d = bus.c_type;
                    if (mask_of(bus.c_type) == '0) state_d = S_ERR;
                    else                           state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                hit     = first_set(mask_of(type_q), 0);
                idx_d   = hit[ING_W-1:0];
                state_d = S_START;
            end
            S_START: begin
                start_d = 1'b1;
                ing_d   = idx_q + ING_W'(1);
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Timer completion takes priority over the watchdog limit.
                if (bus.t_expired) begin
                    state_d = S_NEXT;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WDOG_W'(WDOG_MAX)) state_d = S_ERR;
                end
            end
            S_NEXT: begin
                ing_d = '0;
                hit   = first_set(mask_of(type_q), int'(idx_q) + 1);
                if (hit[ING_W]) begin
                    idx_d   = hit[ING_W-1:0];
                    state_d = S_START;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (bus.cancel) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel aborts an active recipe ahead of timer and watchdog.
        if (bus.cancel && state_q inside {S_LOAD, S_START, S_WAIT, S_NEXT}) begin
            state_d = S_IDLE;
            start_d = 1'b0;
        end

        if (state_d inside {S_IDLE, S_ERR}) ing_d = '0;

        busy_d = (state_d != S_IDLE);
        err_d  = (state_d == S_ERR);
        if (state_d == S_ERR)       led_d = '1;
        else if (state_d == S_IDLE) led_d = '0;
        else                        led_d = NUM_TYPES'(1) << type_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            ing_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            ing_q   <= ing_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            led_q   <= led_d;
        end
    end

    assign bus.ing_type    = ing_q;
    assign bus.start_timer = start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
    assign bus.led         = led_q;

endmodule

// File: doc/coffee_recipe_sequencer.md
Name: coffee_recipe_sequencer

Overview:
Parametrised successor to the coffee-maker control FSM. After a price-OK, it walks a per-type recipe bitmask, issuing one ingredient at a time and handshaking each step with the external dispense timer (start_timer/t_expired). It adds cancel, a per-step watchdog, invalid-type detection and a completion pulse. It sits between the price comparator and the ingredient valves/timer.

Parameters:
NUM_TYPES, 4, number of coffee types.
TYPE_W, 2, width of c_type; must satisfy 2**TYPE_W >= NUM_TYPES.
NUM_ING, 5, number of ingredient valves.
ING_W, 3, width of ing_type; must satisfy 2**ING_W >= NUM_ING+1.
RECIPE, 20'h9B4E3, NUM_TYPES*NUM_ING bits. Slice RECIPE[t*NUM_ING +: NUM_ING] is type t's ingredient mask; bit i means ingredient i is used. Default masks: t0=00011, t1=00111, t2=01101, t3=10011.
WDOG_W, 16, watchdog counter width.
WDOG_MAX, 50000, cycles allowed in WAIT before error.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
comparador_de_precio_ok  in  1  level; payment sufficient, start request.
c_type  in  TYPE_W  requested coffee type; sampled with the start request.
cancel  in  1  abort or error acknowledge; level, sampled each cycle.
t_expired  in  1  external timer done for the current step.
ing_type  out  ING_W  active ingredient, encoded as index+1; 0 = none.
start_timer  out  1  one-cycle pulse that starts the external timer.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on recipe completion.
error  out  1  high while in ERR.
led  out  NUM_TYPES  one-hot of the latched type while busy; all ones in ERR; 0 in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ing_type=0; start_timer=0; busy=0; done=0; error=0; led=0.
  - Latched type, step index and watchdog all cleared.
  - Reset asserted mid-recipe drops all outputs immediately.
- All outputs are registered. States are IDLE, LOAD, START, WAIT, NEXT, DONE, ERR.
- IDLE:
  - If comparador_de_precio_ok=1 and cancel=0, latch c_type.
  - If c_type >= NUM_TYPES, or that type's mask is all zero, go to ERR.
  - Otherwise go to LOAD.
- LOAD (1 cycle): idx = lowest set bit of the mask; go to START.
- START (1 cycle): start_timer=1, ing_type=idx+1, watchdog cleared; go to WAIT.
  - t_expired asserted during START is ignored.
- WAIT:
  - ing_type is held.
  - t_expired=1 goes to NEXT.
  - Otherwise the watchdog increments. Reaching WDOG_MAX goes to ERR.
  - If t_expired and the watchdog limit occur in the same cycle, t_expired wins.
- NEXT (1 cycle):
  - ing_type=0.
  - Search for the next set bit above idx. If found, load idx and go to START; otherwise go to DONE.
  - Masks are never wrapped or revisited; each set bit is dispensed exactly once, in ascending order.
- DONE (1 cycle): done=1; go to IDLE.
  - A price-OK still high in IDLE starts a new order; the upstream deasserts it.
- ERR:
  - error=1, ing_type=0, led all ones.
  - Sticky until cancel=1, then go to IDLE.
- cancel=1 in LOAD, START, WAIT or NEXT:
  - Go to IDLE on the next edge with ing_type=0; no done pulse.
  - cancel beats t_expired and the watchdog.
  - cancel in IDLE blocks a start.
- Latency: price-OK sampled at edge N gives LOAD at N+1 and start_timer high for the cycle after edge N+2.
- Between consecutive steps ing_type is 0 for exactly one cycle (NEXT), so valves never overlap.
- c_type changes after it is latched have no effect until the next order.

Test Plan:
1. Type 2 (mask 01101), price_ok for 1 cycle, t_expired 5 cycles after each start_timer -> ing_type sequence 1, 3, 4 with 0 gaps; three start_timer pulses; done pulses once; led=0100 while busy.
2. Type 0, hold t_expired=1 throughout -> start ignored in START; ing_type 1 then 2; each WAIT lasts exactly 1 cycle; done at cycle 8 after the request.
3. Type 1, no t_expired, WDOG_MAX overridden to 10 -> error=1 and led=1111 after 10 WAIT cycles; stays in ERR until cancel; busy=0 the cycle after cancel.
4. Type 3 cancelled during the second WAIT (ing_type=2) -> next cycle ing_type=0, busy=0, no done pulse; a new type 0 order then completes normally.
5. RECIPE with type 1 mask = 0, request type 1 -> ERR directly from IDLE; start_timer never pulses.
6. rst_n low for 1 cycle mid-WAIT of type 2 -> all outputs 0 asynchronously; after release with price_ok=0 the block stays IDLE.
